rocc_accel_responder: RTL and testbench
=======================================

# rocc_accel_responder

Accelerator-side endpoint of the RoCC command/response interface. Accepts one command at a time from the core-side command channel, decodes the 7-bit funct field, and executes it. The block supports single-cycle arithmetic and accumulator operations and an iterative shift-add multiplier. It returns exactly one result per accepted command on the response channel and honours response backpressure.

## Interface
Parameters:
- XLEN, 64, operand, accumulator and result width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- cmd_valid_i  in  1  command valid from core.
- cmd_ready_o  out  1  accelerator can accept a command.
- cmd_rs1_i  in  XLEN  operand rs1.
- cmd_rs2_i  in  XLEN  operand rs2.
- cmd_instr_i  in  7  funct code.
- resp_valid_o  out  1  response valid.
- resp_data_o  out  XLEN  response data.
- resp_ready_i  in  1  core accepts the response.
- busy_o  out  1  high in any non-IDLE state.
- illegal_o  out  1  sticky flag, set by an unknown funct code.

## Operation
- State machine has three states: IDLE, BUSY, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On a cmd handshake (valid&ready), latch rs1, rs2 and funct.
  - MUL/MAC go to BUSY; all other codes go to RESP with the result registered.
- BUSY:
  - One multiplier bit per cycle, LSB first.
  - If the current bit of the rs2 shadow is 1, then prod += rs1 shadow.
  - Each cycle: rs1 shadow <<= 1, rs2 shadow >>= 1, bit counter decrements from XLEN.
  - After the XLEN-th step, go to RESP. MAC also performs acc += prod at that transition.
- RESP: resp_valid_o=1 and resp_data_o is stable. On resp_ready_i go to IDLE.
- Funct codes (all arithmetic unsigned, modulo 2^XLEN):
  - 0x00 ADD: resp = rs1+rs2.
  - 0x01 ACC_LOAD: acc <= rs1; resp = old acc.
  - 0x02 ACC_ADD: acc <= acc+rs1; resp = new acc.
  - 0x03 MUL: resp = low XLEN bits of rs1*rs2; acc unchanged.
  - 0x04 MAC: acc <= acc + low(rs1*rs2); resp = new acc.
  - 0x05 ACC_READ: resp = acc.
  - Any other code: resp = 0, illegal_o <= 1, acc unchanged.
- acc is updated only at the cycle it is defined for. It never updates on command accept for MUL/MAC.
- cmd inputs are ignored outside IDLE. cmd_ready_o is a pure function of state, with no combinational path from cmd_valid_i.

## Timing
- Reset values:
  - state IDLE, so cmd_ready_o=1 and busy_o=0.
  - resp_valid_o=0, resp_data_o=0, illegal_o=0, acc=0.
  - Shadows, prod and counter = 0.
- Reset mid-operation (BUSY or RESP) abandons the command. No response is emitted and acc returns to 0.
- Single-cycle ops: handshake in cycle T, resp_valid_o high from cycle T+1.
- MUL/MAC: handshake in cycle T, BUSY for cycles T+1..T+XLEN, resp_valid_o high from cycle T+XLEN+1.
  - Latency is fixed: no early exit on a zero multiplier.
- Response handshake in cycle R: resp_valid_o=0 and cmd_ready_o=1 in cycle R+1.
  - Maximum throughput is one single-cycle command per 2 cycles.
- With resp_ready_i low, RESP holds indefinitely, and resp_data_o must not change.
- resp_ready_i is ignored outside RESP.
- Overflow wraps silently: no flag, no saturation.
- Once set, illegal_o stays set until rst_i.

## Test plan
- Reset with rst_i=1 for 2 cycles, then release → cmd_ready_o=1, resp_valid_o=0, busy_o=0, illegal_o=0, and ACC_READ returns 0.
- ADD rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 with resp_ready_i=1 → resp_data_o=1 one cycle after accept, cmd_ready_o=1 the following cycle.
- ACC_LOAD 5 (resp 0), ACC_ADD 7 (resp 12), MAC rs1=3 rs2=4 → MAC response appears exactly 65 cycles after accept with data 24; ACC_READ then returns 24.
- MUL rs1=0x1_0000_0000, rs2=0x1_0000_0001 → resp_data_o=0x1_0000_0000 (wrapped). cmd_ready_o=0 and extra cmd_valid_i pulses are ignored throughout BUSY.
- Backpressure: hold resp_ready_i=0 for 10 cycles during RESP → resp_valid_o and resp_data_o are stable and cmd_ready_o=0; after raising resp_ready_i, one handshake occurs and the block returns to IDLE.
- funct 0x7F → resp 0 and illegal_o=1, which persists; assert rst_i during BUSY of a MUL → no response, acc=0, and the block is in IDLE the next cycle.

Source files
------------

// File: rtl/rocc_accel_responder.sv
// RoCC accelerator endpoint: one command in, one response out.
// Single-cycle ALU/accumulator ops plus an iterative shift-add multiplier.
module rocc_accel_responder #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [XLEN-1:0] cmd_rs1_i,
  input  logic [XLEN-1:0] cmd_rs2_i,
  input  logic [6:0]      cmd_instr_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_data_o,
  input  logic            resp_ready_i,
  output logic            busy_o,
  output logic            illegal_o
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [6:0] F_ADD   = 7'h00;
  localparam logic [6:0] F_LOAD  = 7'h01;
  localparam logic [6:0] F_AADD  = 7'h02;
  localparam logic [6:0] F_MUL   = 7'h03;
  localparam logic [6:0] F_MAC   = 7'h04;
  localparam logic [6:0] F_READ  = 7'h05;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [6:0]      funct_q, funct_d;
  logic [XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] resp_q, resp_d;
  logic            ill_q, ill_d;
  logic [XLEN-1:0] step_prod;

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_data_o  = resp_q;
  assign illegal_o    = ill_q;

  assign step_prod = prod_q + (rs2_q[0] ? rs1_q : '0);

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    funct_d = funct_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    resp_d  = resp_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          rs1_d   = cmd_rs1_i;
          rs2_d   = cmd_rs2_i;
          funct_d = cmd_instr_i;
          state_d = S_RESP;
          unique case (1'b1)
            (cmd_instr_i == F_ADD): resp_d = cmd_rs1_i + cmd_rs2_i;
            (cmd_instr_i == F_LOAD): begin
              acc_d  = cmd_rs1_i;
              resp_d = acc_q;
            end
            (cmd_instr_i == F_AADD): begin
              acc_d  = acc_q + cmd_rs1_i;
              resp_d = acc_q + cmd_rs1_i;
            end
            (cmd_instr_i == F_MUL),
            (cmd_instr_i == F_MAC): begin
              state_d = S_BUSY;
              prod_d  = '0;
              cnt_d   = CW'(XLEN);
            end
            (cmd_instr_i == F_READ): resp_d = acc_q;
            default: begin
              resp_d = '0;
              ill_d  = 1'b1;
            end
          endcase
        end
      end
      S_BUSY: begin
        prod_d = step_prod;
        rs1_d  = rs1_q << 1;
        rs2_d  = rs2_q >> 1;
        cnt_d  = cnt_q - CW'(1);
        // Last multiplier bit: result is final this cycle
        if (cnt_q == CW'(1)) begin
          state_d = S_RESP;
          if (funct_q == F_MAC) begin
            acc_d  = acc_q + step_prod;
            resp_d = acc_q + step_prod;
          end else begin
            resp_d = step_prod;
          end
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      funct_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      resp_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      funct_q <= funct_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      resp_q  <= resp_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_rocc_accel_responder.sv
// Bench for rocc_accel_responder: directed steps plus random commands
// checked against an arithmetic accumulator/latency model.
module tb_rocc_accel_responder;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [XLEN-1:0] cmd_rs1_i;
  logic [XLEN-1:0] cmd_rs2_i;
  logic [6:0]      cmd_instr_i;
  logic            resp_valid_o;
  logic [XLEN-1:0] resp_data_o;
  logic            resp_ready_i;
  logic            busy_o;
  logic            illegal_o;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_acc;
  logic            m_ill;

  always #5 clk = ~clk;

  rocc_accel_responder #(.XLEN(XLEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_rs1_i   (cmd_rs1_i),
    .cmd_rs2_i   (cmd_rs2_i),
    .cmd_instr_i (cmd_instr_i),
    .resp_valid_o(resp_valid_o),
    .resp_data_o (resp_data_o),
    .resp_ready_i(resp_ready_i),
    .busy_o      (busy_o),
    .illegal_o   (illegal_o)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response and latency straight from the funct table
  task automatic model(input logic [6:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b,
                       output logic [XLEN-1:0] r, output int lat);
    lat = 1;
    case (f)
      7'h00: r = a + b;
      7'h01: begin r = m_acc; m_acc = a; end
      7'h02: begin m_acc = m_acc + a; r = m_acc; end
      7'h03: begin r = a * b; lat = XLEN + 1; end
      7'h04: begin m_acc = m_acc + a * b; r = m_acc; lat = XLEN + 1; end
      7'h05: r = m_acc;
      default: begin r = '0; m_ill = 1'b1; end
    endcase
  endtask

  task automatic run(input logic [6:0] f, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input int hold,
                     input bit noise);
    logic [XLEN-1:0] exp;
    int lat;
    int n;
    model(f, a, b, exp, lat);
    chk("ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_instr_i = f;
    cmd_rs1_i   = a;
    cmd_rs2_i   = b;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    n = 1;
    while (!resp_valid_o && n < 200) begin
      chk("busy_ready", cmd_ready_o, 0);
      chk("busy_flag", busy_o, 1);
      if (noise) begin
        cmd_valid_i  = 1'($urandom);
        cmd_instr_i  = 7'($urandom);
        cmd_rs1_i    = {$urandom, $urandom};
        cmd_rs2_i    = {$urandom, $urandom};
        resp_ready_i = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    cmd_valid_i  = 1'b0;
    resp_ready_i = 1'b0;
    chk("latency", n, lat);
    chk("resp_data", resp_data_o, exp);
    for (int i = 0; i < hold; i++) begin
      if (noise) cmd_valid_i = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", resp_valid_o, 1);
      chk("hold_data", resp_data_o, exp);
      chk("hold_ready", cmd_ready_o, 0);
    end
    cmd_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    chk("resp_done", resp_valid_o, 0);
    chk("ready_after", cmd_ready_o, 1);
    chk("busy_after", busy_o, 0);
    chk("illegal", illegal_o, m_ill);
  endtask

  initial begin
    logic [6:0] f;
    int sel;
    rst_i        = 1'b1;
    cmd_valid_i  = 1'b0;
    cmd_rs1_i    = '0;
    cmd_rs2_i    = '0;
    cmd_instr_i  = '0;
    resp_ready_i = 1'b0;
    m_acc        = '0;
    m_ill        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_valid", resp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_data", resp_data_o, 0);

    run(7'h05, 64'h0, 64'h0, 0, 0);
    run(7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 0, 0);
    run(7'h01, 64'd5, 64'd0, 0, 0);
    run(7'h02, 64'd7, 64'd0, 0, 0);
    run(7'h04, 64'd3, 64'd4, 0, 0);
    run(7'h05, 64'h0, 64'h0, 0, 0);
    chk("acc_24", m_acc, 64'd24);
    run(7'h03, 64'h1_0000_0000, 64'h1_0000_0001, 0, 1);
    run(7'h00, 64'h1234, 64'h4321, 10, 1);
    run(7'h04, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 0);
    run(7'h7F, 64'h55, 64'h66, 2, 0);
    chk("illegal_set", illegal_o, 1);
    run(7'h05, 64'h0, 64'h0, 0, 0);

    for (int k = 0; k < 30; k++) begin
      sel = int'($urandom_range(0, 7));
      f = (sel < 6) ? 7'(sel) : 7'($urandom_range(6, 127));
      run(f, {$urandom, $urandom}, {$urandom, $urandom},
          int'($urandom_range(0, 3)), 1'($urandom));
    end

    run(7'h01, 64'hDEAD_BEEF, 64'h0, 0, 0);
    cmd_valid_i = 1'b1;
    cmd_instr_i = 7'h03;
    cmd_rs1_i   = 64'h77;
    cmd_rs2_i   = 64'h99;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", busy_o, 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    m_acc = '0;
    m_ill = 1'b0;
    chk("mr_ready", cmd_ready_o, 1);
    chk("mr_busy", busy_o, 0);
    chk("mr_valid", resp_valid_o, 0);
    chk("mr_illegal", illegal_o, 0);
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      chk("mr_no_resp", resp_valid_o, 0);
    end
    run(7'h05, 64'h0, 64'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
